alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Front-end controller that drives the combinational ALU from the board's single switch bank and push-buttons. It debounces the raw buttons and captures operand A, then operand B, from the switches on successive ENTER presses. It then issues exactly one one-hot opcode to the ALU and latches the ALU's result and flag into stable registers for the display path. It sits between the board I/O and the ALU, and is the producer side of the ALU's `botones`/`A`/`B` interface.

## Interface
- `bits`, 16, operand width; must match the ALU instance.
- `DEBOUNCE`, 1_000_000, consecutive stable cycles required before a debounced button level changes; minimum 1.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw`  in  `bits`  raw switch bank; operand source, sampled without synchronizer.
- `btn_enter`  in  1  raw ENTER button (asynchronous, bouncy).
- `btn_op`  in  4  raw op buttons (+,-,or,and), i.e. bit3 = add, bit0 = and.
- `A`  out  `bits`  registered operand A to the ALU.
- `B`  out  `bits`  registered operand B to the ALU.
- `botones`  out  4  registered one-hot opcode to the ALU; 4'b0000 when idle.
- `salida_in`  in  `bits`+1  ALU result.
- `invalido_in`  in  1  ALU flag: 1 = result fits in `bits`, 0 = overflow/borrow or no op.
- `resultado`  out  `bits`+1  latched ALU result.
- `resultado_ok`  out  1  latched `invalido_in`.
- `resultado_valido`  out  1  high while `resultado` holds a result of the current A/B.
- `estado`  out  2  current state encoding, for LEDs.
- `error`  out  1  one-cycle pulse on a rejected op press.

## Operation
- Input conditioning, per button (5 total):
  - 2-flop synchronizer.
  - Debounce counter: counts while the synced level differs from the debounced level, clears when they match. At count = `DEBOUNCE` the debounced level toggles and the counter clears.
  - Rising-edge pulse = debounced & ~debounced_prev.
  - Falling edges are ignored.
- State machine, `estado` encoding in brackets:
  - CARGA_A [00]: ENTER pulse → A ← `sw`, go to CARGA_B.
  - CARGA_B [01]: ENTER pulse → B ← `sw`, go to ESPERA_OP.
  - ESPERA_OP [10]: op pulse vector exactly one-hot → `botones` ← vector, go to CALC. Zero pulses → stay. More than one pulse in the same cycle → `error` = 1 for that cycle, stay, `botones` unchanged.
  - CALC (also encodes as [10]): one cycle. `resultado` ← `salida_in`, `resultado_ok` ← `invalido_in`, `resultado_valido` ← 1, go to RESULTADO.
  - RESULTADO [11]:
    - One-hot op pulse → new `botones`, go to CALC; A and B are kept.
    - ENTER pulse → `botones` ← 0, `resultado_valido` ← 0, A and B are kept, go to CARGA_A.
    - Multi-hot op pulse → `error` pulse, stay.
- ENTER and op pulses in the same cycle: ENTER wins in CARGA_A, CARGA_B and RESULTADO. In ESPERA_OP the op wins and ENTER is ignored.
- Op pulses in CARGA_A and CARGA_B are ignored, with no `error`.
- `botones` holds its value through CALC and RESULTADO, so the ALU output stays stable for display.
- Arithmetic is done entirely in the ALU; this block does no math. The `bits`+1 result is latched unmodified.

## Timing
- Reset (synchronous, any state, including mid-debounce):
  - State → CARGA_A.
  - A, B, `botones`, `resultado` → 0.
  - `resultado_ok`, `resultado_valido`, `error` → 0.
  - Synchronizers, debounced levels, counters and edge history → 0.
  - A button already held at reset release is seen as a new press after 2 + `DEBOUNCE` cycles.
- Press latency, with edge 1 being the first clock edge at which the raw input is high and stable:
  - Debounced level rises at edge `DEBOUNCE`+2.
  - Edge pulse is high during the following cycle.
  - FSM register update happens at edge `DEBOUNCE`+3.
- Op-to-result latency: ESPERA_OP→CALC at edge N, results latched at edge N+1. `resultado_valido` is high from N+1.
- Bounce shorter than `DEBOUNCE` cycles produces no pulse.
- A press held indefinitely produces exactly one pulse.
- All outputs are registered. `error` is high for exactly one cycle per rejected press.

## Test plan
Parameters: `bits`=8, `DEBOUNCE`=4, with the ALU instantiated.
- Reset mid-operation: assert `reset` in ESPERA_OP with A=0x12 → next cycle `estado`=00, A=B=0, `botones`=0, `resultado`=0, all flags 0.
- Basic add: `sw`=0x0F, ENTER; `sw`=0x01, ENTER; press add → A=0x0F, B=0x01, `botones`=1000, `resultado`=0x010, `resultado_ok`=1, `resultado_valido`=1, `estado`=11. The ENTER update lands exactly 7 cycles after raw ENTER rises.
- Overflow and borrow:
  - A=0xFF, B=0x01, add → `resultado`=0x100, `resultado_ok`=0.
  - Then press sub in RESULTADO → `botones`=0100, `resultado`=0x0FE, `resultado_ok`=1.
  - Fresh A=0x03, B=0x05, sub → `resultado`=0x1FE, `resultado_ok`=0.
- Bounce: toggle `btn_enter` every 2 cycles for 20 cycles, then hold high for 30 cycles → exactly one transition, CARGA_A→CARGA_B.
- Multi-hot rejection: in ESPERA_OP, raise add and and on the same cycle → one `error` pulse, `estado` stays 10, `botones`=0000. A later single or press → `botones`=0010, `resultado`=A|B.
- ENTER/op collision: in RESULTADO, ENTER and sub pulses in the same cycle → `estado`=00, `botones`=0, `resultado_valido`=0.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_sequencer
//  Purpose  : Board front-end for the combinational ALU. Synchronizes and
//             debounces ENTER and the four op buttons, captures operand A and
//             then B from the switch bank, issues one one-hot opcode and
//             latches the ALU result/flag for the display path.
//  Revision : 1.0  initial release
// ============================================================================
module alu_operand_sequencer #(
    parameter int bits     = 16,
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [bits-1:0] sw,
    input  logic            btn_enter,
    input  logic [3:0]      btn_op,
    output logic [bits-1:0] A,
    output logic [bits-1:0] B,
    output logic [3:0]      botones,
    input  logic [bits:0]   salida_in,
    input  logic            invalido_in,
    output logic [bits:0]   resultado,
    output logic            resultado_ok,
    output logic            resultado_valido,
    output logic [1:0]      estado,
    output logic            error
);

    // Counter only has to reach DEBOUNCE-1; one extra edge performs the toggle.
    localparam int c_CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE - 1);

    // State encoding: the low two bits are the LED code, so CALC shares 2'b10
    // with ESPERA_OP and bit 2 tells them apart.
    localparam logic [2:0] S_CARGA_A   = 3'b000;
    localparam logic [2:0] S_CARGA_B   = 3'b001;
    localparam logic [2:0] S_ESPERA_OP = 3'b010;
    localparam logic [2:0] S_CALC      = 3'b110;
    localparam logic [2:0] S_RESULTADO = 3'b011;

    // Bit 4 is ENTER, bits 3:0 are the op buttons in ALU order.
    logic [4:0] w_raw;
    logic [4:0] w_pulse;

    assign w_raw = {btn_enter, btn_op};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            logic            r_sync1;
            logic            r_sync2;
            logic            r_db;
            logic            r_db_prev;
            logic [c_CW-1:0] r_cnt;

            // Synchronize, then require DEBOUNCE consecutive mismatching
            // cycles before the debounced level follows the input.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_db      <= 1'b0;
                    r_db_prev <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_sync1   <= w_raw[gi];
                    r_sync2   <= r_sync1;
                    r_db_prev <= r_db;
                    if (r_sync2 != r_db) begin
                        if (r_cnt == c_CNT_MAX) begin
                            r_db  <= ~r_db;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            // Rising edges only; releases never reach the state machine.
            assign w_pulse[gi] = r_db & ~r_db_prev;
        end
    endgenerate

    logic       w_enter;
    logic [3:0] w_op;
    logic       w_op_one;
    logic       w_op_multi;

    assign w_enter    = w_pulse[4];
    assign w_op       = w_pulse[3:0];
    assign w_op_one   = (w_op != 4'd0) && ((w_op & (w_op - 4'd1)) == 4'd0);
    assign w_op_multi = (w_op != 4'd0) && !w_op_one;

    logic [2:0]      r_state;
    logic [bits-1:0] r_a;
    logic [bits-1:0] r_b;
    logic [3:0]      r_botones;
    logic [bits:0]   r_resultado;
    logic            r_ok;
    logic            r_valido;
    logic            r_error;

    // Operand capture, opcode issue and result latching.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_CARGA_A;
            r_a         <= '0;
            r_b         <= '0;
            r_botones   <= 4'd0;
            r_resultado <= '0;
            r_ok        <= 1'b0;
            r_valido    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_CARGA_A: begin
                    if (w_enter) begin
                        r_a     <= sw;
                        r_state <= S_CARGA_B;
                    end
                end
                S_CARGA_B: begin
                    if (w_enter) begin
                        r_b     <= sw;
                        r_state <= S_ESPERA_OP;
                    end
                end
                S_ESPERA_OP: begin
                    // ENTER is deliberately ignored here; the op decides.
                    if (w_op_one) begin
                        r_botones <= w_op;
                        r_state   <= S_CALC;
                    end else if (w_op_multi) begin
                        r_error <= 1'b1;
                    end
                end
                S_CALC: begin
                    // ALU has had a full cycle with the new opcode applied.
                    r_resultado <= salida_in;
                    r_ok        <= invalido_in;
                    r_valido    <= 1'b1;
                    r_state     <= S_RESULTADO;
                end
                S_RESULTADO: begin
                    if (w_enter) begin
                        r_botones <= 4'd0;
                        r_valido  <= 1'b0;
                        r_state   <= S_CARGA_A;
                    end else if (w_op_one) begin
                        r_botones <= w_op;
                        r_state   <= S_CALC;
                    end else if (w_op_multi) begin
                        r_error <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_CARGA_A;
                end
            endcase
        end
    end

    assign A                = r_a;
    assign B                = r_b;
    assign botones          = r_botones;
    assign resultado        = r_resultado;
    assign resultado_ok     = r_ok;
    assign resultado_valido = r_valido;
    assign estado           = r_state[1:0];
    assign error            = r_error;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_sequencer
//  Purpose  : Directed bench for alu_operand_sequencer (bits=8, DEBOUNCE=4)
//             with a behavioural ALU attached to the opcode/operand outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       btn_enter = 1'b0;
    logic [3:0] btn_op = 4'b0000;
    logic [7:0] dut_a;
    logic [7:0] dut_b;
    logic [3:0] dut_bot;
    logic [8:0] alu_sal;
    logic       alu_ok;
    logic [8:0] dut_res;
    logic       dut_ok;
    logic       dut_val;
    logic [1:0] dut_est;
    logic       dut_err;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.bits(8), .DEBOUNCE(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .sw               (sw),
        .btn_enter        (btn_enter),
        .btn_op           (btn_op),
        .A                (dut_a),
        .B                (dut_b),
        .botones          (dut_bot),
        .salida_in        (alu_sal),
        .invalido_in      (alu_ok),
        .resultado        (dut_res),
        .resultado_ok     (dut_ok),
        .resultado_valido (dut_val),
        .estado           (dut_est),
        .error            (dut_err)
    );

    // Behavioural ALU: 9-bit result, flag high when the result fits in 8 bits.
    always_comb begin
        alu_sal = 9'd0;
        alu_ok  = 1'b0;
        case (dut_bot)
            4'b1000: begin
                alu_sal = {1'b0, dut_a} + {1'b0, dut_b};
                alu_ok  = ~alu_sal[8];
            end
            4'b0100: begin
                alu_sal = {1'b0, dut_a} - {1'b0, dut_b};
                alu_ok  = ~alu_sal[8];
            end
            4'b0010: begin
                alu_sal = {1'b0, dut_a | dut_b};
                alu_ok  = 1'b1;
            end
            4'b0001: begin
                alu_sal = {1'b0, dut_a & dut_b};
                alu_ok  = 1'b1;
            end
            default: begin
                alu_sal = 9'd0;
                alu_ok  = 1'b0;
            end
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [8:0] res;
        logic       ok;
    } vec_t;

    vec_t vecs [7];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold the given buttons long enough for one pulse, then release fully.
    task automatic press(input logic ent, input logic [3:0] op);
        btn_enter = ent;
        btn_op    = op;
        tick(10);
        btn_enter = 1'b0;
        btn_op    = 4'b0000;
        tick(10);
    endtask

    int err_cnt;

    initial begin
        vecs[0] = '{a: 8'hFF, b: 8'h01, op: 4'b1000, res: 9'h100, ok: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, op: 4'b0100, res: 9'h1FE, ok: 1'b0};
        vecs[2] = '{a: 8'hF0, b: 8'h3C, op: 4'b0010, res: 9'h0FC, ok: 1'b1};
        vecs[3] = '{a: 8'hF0, b: 8'h3C, op: 4'b0001, res: 9'h030, ok: 1'b1};
        vecs[4] = '{a: 8'h80, b: 8'h80, op: 4'b1000, res: 9'h100, ok: 1'b0};
        vecs[5] = '{a: 8'h00, b: 8'h00, op: 4'b0100, res: 9'h000, ok: 1'b1};
        vecs[6] = '{a: 8'h7F, b: 8'h01, op: 4'b1000, res: 9'h080, ok: 1'b1};

        // Reset state
        tick(3);
        check("rst_estado", dut_est, 2'b00);
        check("rst_A", dut_a, 8'h00);
        check("rst_botones", dut_bot, 4'b0000);
        check("rst_flags", {dut_ok, dut_val, dut_err}, 3'b000);
        reset = 1'b0;
        tick(2);

        // Basic add, with exact ENTER latency (edge 7 after raw rise)
        sw        = 8'h0F;
        btn_enter = 1'b1;
        tick(6);
        check("lat_edge6_estado", dut_est, 2'b00);
        tick(1);
        check("lat_edge7_estado", dut_est, 2'b01);
        check("lat_edge7_A", dut_a, 8'h0F);
        tick(3);
        btn_enter = 1'b0;
        tick(10);
        sw = 8'h01;
        press(1'b1, 4'b0000);
        press(1'b0, 4'b1000);
        check("add_A", dut_a, 8'h0F);
        check("add_B", dut_b, 8'h01);
        check("add_botones", dut_bot, 4'b1000);
        check("add_res", dut_res, 9'h010);
        check("add_ok_val", {dut_ok, dut_val}, 2'b11);
        check("add_estado", dut_est, 2'b11);

        // Table-driven operations, each starting from RESULTADO
        for (int i = 0; i < 7; i++) begin
            press(1'b1, 4'b0000);
            check($sformatf("v%0d_back_estado", i), dut_est, 2'b00);
            check($sformatf("v%0d_back_val", i), dut_val, 1'b0);
            sw = vecs[i].a;
            press(1'b1, 4'b0000);
            sw = vecs[i].b;
            press(1'b1, 4'b0000);
            check($sformatf("v%0d_wait_estado", i), dut_est, 2'b10);
            press(1'b0, vecs[i].op);
            check($sformatf("v%0d_botones", i), dut_bot, vecs[i].op);
            check($sformatf("v%0d_res", i), dut_res, vecs[i].res);
            check($sformatf("v%0d_ok", i), dut_ok, vecs[i].ok);
            check($sformatf("v%0d_estado", i), dut_est, 2'b11);
        end

        // Overflow add then sub from RESULTADO on the same operands
        press(1'b1, 4'b0000);
        sw = 8'hFF;
        press(1'b1, 4'b0000);
        sw = 8'h01;
        press(1'b1, 4'b0000);
        press(1'b0, 4'b1000);
        check("ovf_res", dut_res, 9'h100);
        check("ovf_ok", dut_ok, 1'b0);
        press(1'b0, 4'b0100);
        check("resub_botones", dut_bot, 4'b0100);
        check("resub_res", dut_res, 9'h0FE);
        check("resub_ok", dut_ok, 1'b1);
        check("resub_A", dut_a, 8'hFF);

        // ENTER and sub together in RESULTADO: ENTER wins
        press(1'b1, 4'b0100);
        check("coll_estado", dut_est, 2'b00);
        check("coll_botones", dut_bot, 4'b0000);
        check("coll_val", dut_val, 1'b0);
        check("coll_A_kept", dut_a, 8'hFF);

        // Multi-hot rejection in ESPERA_OP
        sw = 8'h5A;
        press(1'b1, 4'b0000);
        sw = 8'h0F;
        press(1'b1, 4'b0000);
        err_cnt = 0;
        btn_op  = 4'b1001;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (dut_err) err_cnt++;
        end
        btn_op = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (dut_err) err_cnt++;
        end
        check("multi_err_cycles", err_cnt, 1);
        check("multi_estado", dut_est, 2'b10);
        check("multi_botones", dut_bot, 4'b0000);
        press(1'b0, 4'b0010);
        check("or_botones", dut_bot, 4'b0010);
        check("or_res", dut_res, 9'h05F);
        check("or_estado", dut_est, 2'b11);

        // Bounce on ENTER then a long hold: exactly one transition
        press(1'b1, 4'b0000);
        sw = 8'h12;
        for (int k = 0; k < 10; k++) begin
            btn_enter = (k % 2 == 0);
            tick(2);
        end
        btn_enter = 1'b0;
        tick(4);
        check("bounce_estado", dut_est, 2'b00);
        btn_enter = 1'b1;
        tick(30);
        check("hold_estado", dut_est, 2'b01);
        check("hold_A", dut_a, 8'h12);
        btn_enter = 1'b0;
        tick(10);

        // Reset mid-operation in ESPERA_OP with A=0x12
        sw = 8'h34;
        press(1'b1, 4'b0000);
        check("pre_rst_estado", dut_est, 2'b10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_estado", dut_est, 2'b00);
        check("mid_rst_AB", {dut_a, dut_b}, 16'h0000);
        check("mid_rst_botones", dut_bot, 4'b0000);
        check("mid_rst_res", dut_res, 9'h000);
        check("mid_rst_flags", {dut_ok, dut_val, dut_err}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
